multicycle_control_fsm: RTL and testbench
=========================================

Name: multicycle_control_fsm

Overview:
- Main sequencing controller for the multicycle MIPS datapath.
- Steps each instruction through fetch/decode/execute/memory/writeback states.
- Drives all datapath mux selects, including the 2-bit write-data select (`mem_to_reg`) into the register-file write-data 4:1 mux, plus the ALU, PC and memory enables.
- Stalls on a memory ready handshake and flags illegal opcodes and memory timeouts.

Parameters:
- MEM_TIMEOUT, 255: wait cycles on `mem_ready` before `mem_timeout` sets. Range 0..255; 0 disables the check.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  IR[31:26]; stable from DECODE onward
- zero  in  1  ALU zero flag; datapath qualifies `pc_write_cond` with it
- mem_ready  in  1  memory completes the current read/write this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if `zero`
- iord  out  1  0 = PC address, 1 = ALUOut address
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  IR load
- mem_to_reg  out  2  write-data select: 00 ALUOut, 01 MDR, 10 PC, 11 {imm,16'b0}
- reg_dst  out  2  dest select: 00 rt, 01 rd, 10 $31
- reg_write  out  1  register-file write enable
- alu_src_a  out  1  0 PC, 1 A
- alu_src_b  out  2  00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
- alu_op  out  2  00 add, 01 sub, 10 funct decode
- pc_source  out  2  00 ALU result, 01 ALUOut, 10 jump target
- illegal_op  out  1  one-cycle pulse in DECODE for an unsupported opcode
- mem_timeout  out  1  sticky timeout flag
- state  out  4  current state encoding (debug)

Behaviour:
- Moore FSM with a 4-bit state register.
- Outputs are a combinational decode of state. The write strobes in FETCH are additionally gated by `mem_ready`.
- Every output not listed for a state is 0.
- Reset (`rst_n` = 0, asynchronous, any time including mid-instruction):
  - state goes to IDLE (0);
  - all outputs read 0;
  - timeout counter clears to 0; `mem_timeout` clears to 0.
- Opcodes: R 000000, lw 100011, sw 101011, beq 000100, addi 001000, lui 001111, j 000010, jal 000011.
- States, their outputs and transitions:
  - IDLE (0): all outputs 0. -> FETCH on the first clock after reset release.
  - FETCH (1): `mem_read`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=00, `pc_source`=00. `ir_write`=`pc_write`=`mem_ready`. Stays in FETCH while `mem_ready`=0. -> DECODE when `mem_ready`=1.
  - DECODE (2): `alu_src_a`=0, `alu_src_b`=11, `alu_op`=00. Branches on `opcode`:
    - lw/sw -> MEMADR
    - R -> RTYPEEX
    - beq -> BEQEX
    - addi -> ADDIEX
    - lui -> LUIWB
    - j -> JEX
    - jal -> JALWB
    - any other opcode -> FETCH, with `illegal_op`=1 for this cycle.
  - MEMADR (3): `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00. -> MEMRD for lw, MEMWR for sw.
  - MEMRD (4): `iord`=1, `mem_read`=1. Stays while `mem_ready`=0. -> MEMWB when `mem_ready`=1.
  - MEMWB (5): `reg_dst`=00, `mem_to_reg`=01, `reg_write`=1. -> FETCH.
  - MEMWR (6): `iord`=1, `mem_write`=1, held until `mem_ready`. -> FETCH when `mem_ready`=1.
  - RTYPEEX (7): `alu_src_a`=1, `alu_src_b`=00, `alu_op`=10. -> RTYPEWB.
  - RTYPEWB (8): `reg_dst`=01, `mem_to_reg`=00, `reg_write`=1. -> FETCH.
  - BEQEX (9): `alu_src_a`=1, `alu_src_b`=00, `alu_op`=01, `pc_write_cond`=1, `pc_source`=01. -> FETCH.
  - ADDIEX (10): `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00. -> ITYPEWB.
  - ITYPEWB (11): `reg_dst`=00, `mem_to_reg`=00, `reg_write`=1. -> FETCH.
  - LUIWB (12): `reg_dst`=00, `mem_to_reg`=11, `reg_write`=1. -> FETCH.
  - JEX (13): `pc_write`=1, `pc_source`=10. -> FETCH.
  - JALWB (14): `reg_dst`=10, `mem_to_reg`=10, `reg_write`=1, `pc_write`=1, `pc_source`=10. -> FETCH.
  - Encoding 15 is unused. If reached, -> FETCH with all outputs 0.
- Latency with zero-wait memory (`mem_ready` tied 1), in cycles:
  - lw 5; sw 4; R 4; addi 4; beq 3; j 3; jal 3; lui 3.
  - Each wait cycle in FETCH/MEMRD/MEMWR adds 1.
- Timeout counter (8-bit):
  - Increments each cycle in FETCH, MEMRD or MEMWR with `mem_ready`=0.
  - Clears to 0 on any cycle not in those states, or whenever `mem_ready`=1.
  - Saturates at 255.
  - When it equals MEM_TIMEOUT (and MEM_TIMEOUT≠0), `mem_timeout` sets to 1 on the next edge and stays set until reset.
  - The FSM keeps waiting; there is no abort.
- A `mem_ready` pulse arriving in any other state is ignored.

Optional Feature:
- Macro: `MULTICYCLE_JAL_EN`.
- Defined: jal (000011) decodes to JALWB as described above.
- Undefined:
  - JALWB is not built; encoding 14 behaves like 15.
  - jal is treated as illegal: `illegal_op` pulses, FSM returns to FETCH, and no register or PC write occurs.

Test Plan:
- Reset: `rst_n`=0 mid-MEMRD -> state=0 and all outputs 0 immediately, with no clock edge; after release, IDLE then FETCH next edge.
- lw, `mem_ready`=1: state sequence 1,2,3,4,5,1 -> `reg_write`=1 with `mem_to_reg`=01, `reg_dst`=00, in cycle 5 only.
- sw with `mem_ready` low 3 cycles in MEMWR -> `mem_write`=1 for exactly 4 cycles, `iord`=1 throughout, then FETCH; `reg_write` never asserts.
- FETCH wait: `mem_ready`=0 for 2 cycles -> `ir_write`/`pc_write` stay 0 during the wait and pulse 1 on the ready cycle only; MEM_TIMEOUT=2 -> `mem_timeout` sets and stays 1 through the following instructions.
- lui then R-type -> LUIWB with `mem_to_reg`=11; RTYPEEX with `alu_op`=10, then RTYPEWB with `reg_dst`=01.
- opcode 111111 -> `illegal_op`=1 for one DECODE cycle, next state FETCH; jal: macro on -> JALWB with `mem_to_reg`=10, `reg_dst`=10, `pc_source`=10; macro off -> same response as 111111.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute/memory/writeback.
// Optional jal support is built when MULTICYCLE_JAL_EN is defined.
module multicycle_control_fsm #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] mem_to_reg,
  output logic [1:0] reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       illegal_op,
  output logic       mem_timeout,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,  S_FETCH   = 4'd1,  S_DECODE  = 4'd2,  S_MEMADR  = 4'd3,
    S_MEMRD   = 4'd4,  S_MEMWB   = 4'd5,  S_MEMWR   = 4'd6,  S_RTYPEEX = 4'd7,
    S_RTYPEWB = 4'd8,  S_BEQEX   = 4'd9,  S_ADDIEX  = 4'd10, S_ITYPEWB = 4'd11,
    S_LUIWB   = 4'd12, S_JEX     = 4'd13, S_JALWB   = 4'd14, S_BAD     = 4'd15
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [7:0] TO_LIM  = MEM_TIMEOUT[7:0];

  state_t     r_state, w_next;
  logic [7:0] r_cnt;
  logic       r_timeout;
  logic       w_wait;
  // The branch decision on zero is made in the datapath, not here.
  logic       w_unused_zero;

  assign w_unused_zero = zero;
  assign state         = r_state;
  assign mem_timeout   = r_timeout;
  assign w_wait        = ((r_state == S_FETCH) || (r_state == S_MEMRD) ||
                          (r_state == S_MEMWR)) && !mem_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= 8'd0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_wait) r_cnt <= (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;
      else        r_cnt <= 8'd0;
      // Sticky: the FSM keeps waiting, software inspects the flag.
      if ((TO_LIM != 8'd0) && (r_cnt == TO_LIM)) r_timeout <= 1'b1;
    end
  end

  always_comb begin
    w_next        = r_state;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 2'b00;
    reg_dst       = 2'b00;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    illegal_op    = 1'b0;
    case (r_state)
      S_IDLE: w_next = S_FETCH;
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) w_next = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_R:         w_next = S_RTYPEEX;
          OP_BEQ:       w_next = S_BEQEX;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_LUI:       w_next = S_LUIWB;
          OP_J:         w_next = S_JEX;
`ifdef MULTICYCLE_JAL_EN
          OP_JAL:       w_next = S_JALWB;
`endif
          default: begin
            illegal_op = 1'b1;
            w_next     = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        w_next    = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
        if (mem_ready) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        mem_to_reg = 2'b01;
        reg_write  = 1'b1;
        w_next     = S_FETCH;
      end
      S_MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) w_next = S_FETCH;
      end
      S_RTYPEEX: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        w_next    = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        reg_dst   = 2'b01;
        reg_write = 1'b1;
        w_next    = S_FETCH;
      end
      S_BEQEX: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        w_next        = S_FETCH;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        w_next    = S_ITYPEWB;
      end
      S_ITYPEWB: begin
        reg_write = 1'b1;
        w_next    = S_FETCH;
      end
      S_LUIWB: begin
        mem_to_reg = 2'b11;
        reg_write  = 1'b1;
        w_next     = S_FETCH;
      end
      S_JEX: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        w_next    = S_FETCH;
      end
`ifdef MULTICYCLE_JAL_EN
      S_JALWB: begin
        reg_dst    = 2'b10;
        mem_to_reg = 2'b10;
        reg_write  = 1'b1;
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        w_next     = S_FETCH;
      end
`endif
      default: w_next = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: directed table, reset corner, random instruction stream.
module tb_multicycle_control_fsm;

  localparam int TO = 2;
`ifdef MULTICYCLE_JAL_EN
  localparam bit JAL_ON = 1'b1;
`else
  localparam bit JAL_ON = 1'b0;
`endif
  localparam int NEVER = 32'h7fffffff;

  logic clk = 1'b0, rst_n = 1'b0, zero = 1'b0, mem_ready = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, reg_write;
  logic alu_src_a, illegal_op, mem_timeout;
  logic [1:0] mem_to_reg, reg_dst, alu_src_b, alu_op, pc_source;
  logic [3:0] state;

  multicycle_control_fsm #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .illegal_op(illegal_op), .mem_timeout(mem_timeout),
    .state(state));

  always #5 clk = ~clk;

  int nchk = 0, nerr = 0, cyc = 0, set_cyc = NEVER;

  typedef struct { logic [5:0] op; int fw; int mw; int lat; } vec_t;
  vec_t tbl[12];

  function automatic logic [18:0] act_out();
    return {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg,
            reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op};
  endfunction

  function automatic bit legal(logic [5:0] op);
    case (op)
      6'b000000, 6'b100011, 6'b101011, 6'b000100,
      6'b001000, 6'b001111, 6'b000010: return 1'b1;
      6'b000011: return JAL_ON;
      default:   return 1'b0;
    endcase
  endfunction

  // Output table from the state descriptions: {pcw,pwc,iord,mrd,mwr,irw,m2r,rdst,rw,a,b,aluop,pcsrc,ill}
  function automatic logic [18:0] exp_out(int st, logic rdy, logic [5:0] op);
    logic pcw, pwc, io, mrd, mwr, irw, rw, a, ill;
    logic [1:0] m2r, rd, b, ao, ps;
    {pcw, pwc, io, mrd, mwr, irw, rw, a, ill} = '0;
    {m2r, rd, b, ao, ps} = '0;
    case (st)
      1:  begin mrd = 1; b = 2'b01; irw = rdy; pcw = rdy; end
      2:  begin b = 2'b11; ill = !legal(op); end
      3:  begin a = 1; b = 2'b10; end
      4:  begin io = 1; mrd = 1; end
      5:  begin m2r = 2'b01; rw = 1; end
      6:  begin io = 1; mwr = 1; end
      7:  begin a = 1; ao = 2'b10; end
      8:  begin rd = 2'b01; rw = 1; end
      9:  begin a = 1; ao = 2'b01; pwc = 1; ps = 2'b01; end
      10: begin a = 1; b = 2'b10; end
      11: rw = 1;
      12: begin m2r = 2'b11; rw = 1; end
      13: begin pcw = 1; ps = 2'b10; end
      14: if (JAL_ON) begin rd = 2'b10; m2r = 2'b10; rw = 1; pcw = 1; ps = 2'b10; end
      default: ;
    endcase
    return {pcw, pwc, io, mrd, mwr, irw, m2r, rd, rw, a, b, ao, ps, ill};
  endfunction

  function automatic int base_lat(logic [5:0] op);
    case (op)
      6'b100011: return 5;
      6'b101011, 6'b000000, 6'b001000: return 4;
      6'b000100, 6'b000010, 6'b001111: return 3;
      6'b000011: return JAL_ON ? 3 : 2;
      default:   return 2;
    endcase
  endfunction

  task automatic chk(string name, int got, int want);
    nchk++;
    if (got != want) begin
      nerr++;
      $display("FAIL %s at cycle %0d: got %0h want %0h", name, cyc, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  // Expected per-cycle trace built as state/ready lists from the instruction's path.
  task automatic run_instr(logic [5:0] op, int fw, int mw, int lat);
    int sq[$];
    int rq[$];   // 0 = stalled, 1 = ready, 2 = don't care
    int runlen = 0, start = 0, n;
    repeat (fw) begin sq.push_back(1); rq.push_back(0); end
    sq.push_back(1); rq.push_back(1);
    sq.push_back(2); rq.push_back(2);
    case (op)
      6'b100011: begin
        sq.push_back(3); rq.push_back(2);
        repeat (mw) begin sq.push_back(4); rq.push_back(0); end
        sq.push_back(4); rq.push_back(1);
        sq.push_back(5); rq.push_back(2);
      end
      6'b101011: begin
        sq.push_back(3); rq.push_back(2);
        repeat (mw) begin sq.push_back(6); rq.push_back(0); end
        sq.push_back(6); rq.push_back(1);
      end
      6'b000000: begin sq.push_back(7); rq.push_back(2); sq.push_back(8); rq.push_back(2); end
      6'b001000: begin sq.push_back(10); rq.push_back(2); sq.push_back(11); rq.push_back(2); end
      6'b000100: begin sq.push_back(9); rq.push_back(2); end
      6'b001111: begin sq.push_back(12); rq.push_back(2); end
      6'b000010: begin sq.push_back(13); rq.push_back(2); end
      6'b000011: if (JAL_ON) begin sq.push_back(14); rq.push_back(2); end
      default: ;
    endcase
    for (int i = 0; i < sq.size(); i++) begin
      opcode    = op;
      mem_ready = (rq[i] == 2) ? 1'($urandom_range(0, 1)) : 1'(rq[i]);
      if (rq[i] == 0) begin
        if (runlen == 0) start = cyc;
        runlen++;
        if (runlen == TO && start + TO + 1 < set_cyc) set_cyc = start + TO + 1;
      end else runlen = 0;
      #1;
      chk("state", int'(state), sq[i]);
      chk("outputs", int'(act_out()), int'(exp_out(sq[i], mem_ready, op)));
      chk("mem_timeout", int'(mem_timeout), int'(cyc >= set_cyc));
      step();
    end
    n = sq.size();
    while (state != 4'd1 && n < 40) begin
      mem_ready = 1'b1;
      step();
      n++;
    end
    chk("latency", n, lat);
  endtask

  initial begin
    tbl[0]  = '{6'b100011, 0, 0, 5};
    tbl[1]  = '{6'b000000, 1, 0, 5};
    tbl[2]  = '{6'b001111, 0, 0, 3};
    tbl[3]  = '{6'b000000, 0, 0, 4};
    tbl[4]  = '{6'b000100, 0, 0, 3};
    tbl[5]  = '{6'b000010, 0, 0, 3};
    tbl[6]  = '{6'b000011, 0, 0, JAL_ON ? 3 : 2};
    tbl[7]  = '{6'b111111, 0, 0, 2};
    tbl[8]  = '{6'b001000, 2, 0, 6};
    tbl[9]  = '{6'b101011, 0, 3, 7};
    tbl[10] = '{6'b100011, 1, 2, 8};
    tbl[11] = '{6'b001000, 0, 0, 4};

    #2;
    chk("rst_state", int'(state), 0);
    chk("rst_outputs", int'(act_out()), 0);
    chk("rst_timeout", int'(mem_timeout), 0);
    step(); step();
    rst_n = 1'b1;
    #1;
    chk("idle_state", int'(state), 0);
    step();
    chk("first_fetch", int'(state), 1);

    foreach (tbl[k]) run_instr(tbl[k].op, tbl[k].fw, tbl[k].mw, tbl[k].lat);

    // Asynchronous reset in the middle of a stalled load.
    opcode = 6'b100011; mem_ready = 1'b1;
    step(); step(); step();
    mem_ready = 1'b0;
    #1;
    chk("pre_rst_memrd", int'(state), 4);
    rst_n = 1'b0;
    #1;
    chk("async_rst_state", int'(state), 0);
    chk("async_rst_outputs", int'(act_out()), 0);
    chk("async_rst_timeout", int'(mem_timeout), 0);
    set_cyc = NEVER;
    step();
    rst_n = 1'b1;
    #1;
    chk("post_rst_idle", int'(state), 0);
    step();
    chk("post_rst_fetch", int'(state), 1);

    for (int k = 0; k < 60; k++) begin
      logic [5:0] ops[10];
      logic [5:0] op;
      int fw, mw;
      ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000,
              6'b001111, 6'b000010, 6'b000011, 6'b111111, 6'b010101};
      op = ops[$urandom_range(0, 9)];
      fw = $urandom_range(0, 3);
      mw = $urandom_range(0, 3);
      run_instr(op, fw, mw,
                base_lat(op) + fw + ((op == 6'b100011 || op == 6'b101011) ? mw : 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
